uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Single-clock UART receiver and command decoder for the EGO1 serial link. It accepts the 8-bit command frames that the transmitting end sends at 9600 baud, 8N1. Each byte carries `{1'b1, payload[6:0]}`, where bit 7 is the validation bit and bits 3:0 are the forward/backward/left/right controls. The block oversamples the line ×16 with an internally generated tick, so no separate baud-clock divider is needed. Accepted bytes are placed in a holding register with a valid/read handshake, and the movement nibble is published on `cmd`.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `BAUD`, 9600, line rate.
- `DIV`, derived as (CLK_HZ + BAUD*8)/(BAUD*16), giving 651 at the defaults; clocks per oversample tick; minimum 2.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial line; idle high; asynchronous to `clk`.
- `rd`  in  1  read strobe; consumes the holding register.
- `data_out`  out  8  last accepted byte.
- `data_valid`  out  1  `data_out` holds an unread byte.
- `cmd`  out  4  movement nibble: bit3 fwd, bit2 back, bit1 left, bit0 right.
- `cmd_valid`  out  1  one-cycle pulse when `cmd` updates.
- `cmd_err`  out  1  one-cycle pulse: good frame received, but bit 7 = 0.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  sticky: a good frame was dropped because the holding register was full.

## Operation
- **Input synchroniser:** `rxd` passes through 2 flops; both reset to 1. All logic uses the synchronised value `rxs`.
- **Tick generator:** counter runs 0..DIV-1 and emits `tick` when the count reaches DIV-1. The counter is forced to 0 on the IDLE→START transition. A 4-bit sample index counts 0..15 per bit.
- **Majority vote:** each bit value is the majority of `rxs` at sample indices 7, 8 and 9. The vote is evaluated on tick 9.
- **State machine:**
  - IDLE: if `rxs`=0, clear the tick counter and sample index, then go to START.
  - START: on vote = 1 (false start), go to IDLE. On vote = 0, wait for sample 15, then go to DATA with bit count 0.
  - DATA: shift the voted bit in LSB first. After bit 7's sample 15, go to STOP.
  - STOP: on vote = 1 (good frame), go to IDLE immediately at sample 9; do not wait for sample 15. On vote = 0, pulse `frame_err`, discard the byte and go to RECOVER.
  - RECOVER: wait for `rxs`=1, then go to IDLE.
- **Good frame, holding register:**
  - If `data_valid`=0, or `rd`=1 in the same cycle, load `data_out` and set `data_valid`=1.
  - Otherwise keep the old byte, drop the new one and set `overrun`.
- **Good frame, command decode:**
  - If byte[7]=1: `cmd` <= byte[3:0] and pulse `cmd_valid`.
  - If byte[7]=0: pulse `cmd_err` and hold `cmd`.
  - The holding register receives the byte in both cases.
- **Read strobe:** `rd` with `data_valid`=1 clears `data_valid` and `overrun`. `rd` with `data_valid`=0 is ignored.

## Timing
- **Reset values:** `data_out`=0, `data_valid`=0, `cmd`=0, `cmd_valid`=0, `cmd_err`=0, `frame_err`=0, `overrun`=0, state IDLE.
- **Reset is asynchronous:** asserting `rst` mid-frame aborts the frame and discards partial data. After release, a frame is received only if its start edge is seen from IDLE.
- **Line-to-detect latency:** 2 clocks from `rxd` falling to `rxs`=0; detection takes effect the cycle after that.
- **Tick spacing:** tick n occurs n×DIV clocks after detection. The stop vote is tick 154 (9×16+10).
- **Result latency:** `data_valid`, `cmd`, `cmd_valid` and `cmd_err` update on the clock edge after the stop-vote tick. `frame_err` also pulses on that edge.
- **Back-to-back frames:** supported. IDLE is re-entered at stop sample 9, which leaves more than 6 ticks of margin for the next start edge.
- **Pulse width:** `cmd_valid`, `cmd_err` and `frame_err` are each exactly 1 clock.
- **Mutual exclusion:** at most one of `cmd_valid` or `cmd_err` pulses per frame. `frame_err` never pulses together with either.
- **Simultaneous events:** `rd` in the same cycle as a new good frame loads the new byte with no overrun. `data_valid` stays 1 in that case.

## Test plan
- **Basic command:** reset, then send 0x89 at 9600 baud. Required: `data_out`=0x89, `data_valid`=1, `cmd`=4'b1001 with a 1-cycle `cmd_valid`, about 100254 clocks after detection. `rd` then clears `data_valid`.
- **Invalid command:** send 0x05. Required: `data_out`=0x05, `data_valid`=1, one `cmd_err` pulse, `cmd` unchanged from the previous value.
- **Glitch and framing error:**
  - A 3-tick low glitch on `rxd` gives no output, and the block returns to IDLE.
  - A frame 0xA3 with the stop bit held low gives one `frame_err` pulse and `data_valid` stays 0.
  - With the line then held low for 2 bit times before the next frame (0x81), the block stays in RECOVER while the line is low. 0x81 is then received correctly.
- **Overrun:** send 0x81 then 0x82 with no `rd`. Required: `data_out`=0x81 and `overrun`=1. `rd` clears both `data_valid` and `overrun`.
- **Read collision:** assert `rd` exactly on the result cycle of a second frame 0x84. Required: `data_out`=0x84, `data_valid`=1, `overrun`=0.
- **Reset and baud tolerance:**
  - Assert `rst` low during DATA bit 4, release, then send 0x88. Only 0x88 is reported.
  - Repeat the basic case with the line at ±2% baud error. All bytes are received correctly.

Source files
------------

// File: rtl/uart_cmd_rx_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx_if
// Groups the serial line, the read strobe and all receiver results of
// uart_cmd_rx into one bundle.
//   slave  : receiver side (samples rxd/rd, drives results)
//   master : host side (drives rxd/rd, observes results)
// Signals:
//   rxd        serial line, idle high, asynchronous to clk
//   rd         read strobe, consumes the holding register
//   data_out   last accepted byte
//   data_valid data_out holds an unread byte
//   cmd        movement nibble {fwd, back, left, right}
//   cmd_valid  1-clock pulse when cmd updates
//   cmd_err    1-clock pulse: good frame with validation bit clear
//   frame_err  1-clock pulse: stop bit sampled low
//   overrun    sticky: good frame dropped because holding register was full
// ---------------------------------------------------------------------------
interface uart_cmd_rx_if;
    logic       rxd;
    logic       rd;
    logic [7:0] data_out;
    logic       data_valid;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       cmd_err;
    logic       frame_err;
    logic       overrun;

    modport slave (
        input  rxd,
        input  rd,
        output data_out,
        output data_valid,
        output cmd,
        output cmd_valid,
        output cmd_err,
        output frame_err,
        output overrun
    );

    modport master (
        output rxd,
        output rd,
        input  data_out,
        input  data_valid,
        input  cmd,
        input  cmd_valid,
        input  cmd_err,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
// 8N1 UART receiver with x16 oversampling and a command decoder for the
// EGO1 serial link. Each bit is the majority of samples 7/8/9; good frames
// go to a holding register with a valid/read handshake, and frames with the
// validation bit (bit 7) set publish their low nibble on cmd.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   uart_cmd_rx_if.slave (rxd, rd in; data/flags out)
// Parameters:
//   CLK_HZ  system clock frequency
//   BAUD    line rate
// ---------------------------------------------------------------------------
module uart_cmd_rx #(
    parameter int unsigned CLK_HZ = 32'd100_000_000,
    parameter int unsigned BAUD   = 32'd9600
) (
    input  logic           clk,
    input  logic           rst,
    uart_cmd_rx_if.slave   bus
);

    // Clocks per oversample tick, rounded to nearest, never below 2.
    localparam int unsigned DIV_RAW  = (CLK_HZ + BAUD * 32'd8) / (BAUD * 32'd16);
    localparam int unsigned DIV_USE  = (DIV_RAW < 32'd2) ? 32'd2 : DIV_RAW;
    localparam int          CW       = $clog2(DIV_USE);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_USE - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    // Two-of-three majority of the mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0]    sync_q;
    logic          rxs_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          s7_q, s7_d;
    logic          s8_q, s8_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_err_q, cmd_err_d;
    logic          frame_err_q, frame_err_d;
    logic          ovr_q, ovr_d;

    logic          tick_s;
    logic          vote_s;
    logic          at_s9_s;
    logic          at_s15_s;
    logic          good_s;

    assign rxs_s    = sync_q[1];
    assign tick_s   = (cnt_q == DIV_LAST);
    assign vote_s   = maj3(s7_q, s8_q, rxs_s);
    assign at_s9_s  = tick_s && (idx_q == 4'd9);
    assign at_s15_s = tick_s && (idx_q == 4'd15);

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rxd};
        end
    end

    // Next-state logic for the receive FSM, bit sampling and result registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = tick_s ? '0 : cnt_q + CW'(1);
        idx_d       = tick_s ? idx_q + 4'd1 : idx_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        s7_d        = (tick_s && (idx_q == 4'd7)) ? rxs_s : s7_q;
        s8_d        = (tick_s && (idx_q == 4'd8)) ? rxs_s : s8_q;
        data_d      = data_q;
        dv_d        = dv_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        frame_err_d = 1'b0;
        ovr_d       = ovr_q;
        good_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Start edge: realign the tick phase to the falling edge.
                if (!rxs_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (at_s9_s && vote_s) begin
                    state_d = ST_IDLE;
                end else if (at_s15_s) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (at_s9_s) begin
                    shift_d = {vote_s, shift_q[7:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (at_s15_s) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                // Leave at sample 9 so a back-to-back start edge is not missed.
                if (at_s9_s) begin
                    if (vote_s) begin
                        good_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_RECOVER;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_RECOVER: begin
                if (rxs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A read of an unread byte frees the register and clears overrun.
        if (bus.rd && dv_q) begin
            dv_d  = 1'b0;
            ovr_d = 1'b0;
        end else begin
            dv_d  = dv_q;
            ovr_d = ovr_q;
        end

        // A read in the same cycle as a good frame counts as free space.
        if (good_s) begin
            if (!dv_q || bus.rd) begin
                data_d = shift_q;
                dv_d   = 1'b1;
            end else begin
                ovr_d  = 1'b1;
            end
            if (shift_q[7]) begin
                cmd_d       = shift_q[3:0];
                cmd_valid_d = 1'b1;
            end else begin
                cmd_err_d   = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // State, sampling and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            data_q      <= 8'd0;
            dv_q        <= 1'b0;
            cmd_q       <= 4'd0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            frame_err_q <= frame_err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx
// Drives serial frames into uart_cmd_rx and compares every result pulse
// against expectations queued when the frame was sent. A reduced clock
// frequency keeps the oversample divider at 7 (112 clocks per bit).
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;

    localparam int unsigned CLK_HZ   = 32'd1_000_000;
    localparam int unsigned BAUD     = 32'd9600;
    localparam int          DIV      = 7;
    localparam int          BIT_CLKS = 16 * DIV;
    // Drive edge to result edge: 3 clocks sync/detect + 154 ticks.
    localparam int          LAT      = 3 + 154 * DIV;

    typedef struct {
        logic [2:0] pulse;   // {cmd_valid, cmd_err, frame_err}
        logic [7:0] data;
        logic       dv;
        logic [3:0] cmd;
        logic       ovr;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   t_drive = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    // Reference model of the visible receiver state.
    logic [7:0] m_data = 8'd0;
    logic       m_dv   = 1'b0;
    logic [3:0] m_cmd  = 4'd0;
    logic       m_ovr  = 1'b0;

    logic [2:0] pulse_s;
    logic [2:0] prev_pulse = 3'd0;

    uart_cmd_rx_if bus();

    uart_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign pulse_s = {bus.cmd_valid, bus.cmd_err, bus.frame_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare each result pulse with the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_pulse != 3'd0) chk("pulse_width", 32'(pulse_s), 32'd0);
            if (pulse_s != 3'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'(pulse_s), 32'd0);
                end else begin
                    chk("ev_pulse", 32'(pulse_s),        32'(sb[0].pulse));
                    chk("ev_data",  32'(bus.data_out),   32'(sb[0].data));
                    chk("ev_dv",    32'(bus.data_valid), 32'(sb[0].dv));
                    chk("ev_cmd",   32'(bus.cmd),        32'(sb[0].cmd));
                    chk("ev_ovr",   32'(bus.overrun),    32'(sb[0].ovr));
                    if (sb[0].lat) chk("ev_latency", 32'(cyc - t_drive), 32'(LAT));
                    void'(sb.pop_front());
                end
            end
        end
        prev_pulse <= pulse_s;
    end

    // Expected outcome of a good frame; rd_hit = rd asserted on its result cycle.
    task automatic exp_frame(input logic [7:0] b, input bit rd_hit, input bit lat);
        exp_t e;
        if (rd_hit && m_dv) begin
            m_dv  = 1'b0;
            m_ovr = 1'b0;
        end
        if (!m_dv) begin
            m_data = b;
            m_dv   = 1'b1;
        end else begin
            m_ovr  = 1'b1;
        end
        if (b[7]) begin
            m_cmd   = b[3:0];
            e.pulse = 3'b100;
        end else begin
            e.pulse = 3'b010;
        end
        e.data = m_data; e.dv = m_dv; e.cmd = m_cmd; e.ovr = m_ovr; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic exp_ferr();
        exp_t e;
        e.pulse = 3'b001;
        e.data = m_data; e.dv = m_dv; e.cmd = m_cmd; e.ovr = m_ovr; e.lat = 1'b0;
        sb.push_back(e);
    endtask

    // Called at a falling edge; leaves the line idle high afterwards.
    task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_lvl);
        t_drive = cyc;
        bus.rxd = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            repeat (bclk) @(negedge clk);
        end
        bus.rxd = stop_lvl;
        repeat (bclk) @(negedge clk);
        bus.rxd = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * BIT_CLKS && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic do_rd();
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        if (m_dv) begin
            m_dv  = 1'b0;
            m_ovr = 1'b0;
        end
        chk("rd_dv",  32'(bus.data_valid), 32'(m_dv));
        chk("rd_ovr", 32'(bus.overrun),    32'(m_ovr));
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rxd = 1'b1;
        bus.rd  = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_data",  32'(bus.data_out),   32'd0);
        chk("rst_dv",    32'(bus.data_valid), 32'd0);
        chk("rst_cmd",   32'(bus.cmd),        32'd0);
        chk("rst_ovr",   32'(bus.overrun),    32'd0);
        chk("rst_pulse", 32'(pulse_s),        32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Basic command, exact latency
        exp_frame(8'h89, 1'b0, 1'b1);
        send_frame(8'h89, BIT_CLKS, 1'b1);
        wait_drain();
        do_rd();

        // Invalid command holds cmd
        exp_frame(8'h05, 1'b0, 1'b0);
        send_frame(8'h05, BIT_CLKS, 1'b1);
        wait_drain();
        chk("cmd_hold", 32'(bus.cmd), 32'h9);
        do_rd();

        // 3-tick glitch: no output
        bus.rxd = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("glitch_dv", 32'(bus.data_valid), 32'd0);

        // Framing error, then line low for 2 bit times
        exp_ferr();
        send_frame(8'hA3, BIT_CLKS, 1'b0);
        bus.rxd = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("ferr_dv", 32'(bus.data_valid), 32'd0);
        bus.rxd = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        wait_drain();
        exp_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, BIT_CLKS, 1'b1);
        wait_drain();
        do_rd();

        // Overrun, back-to-back frames
        exp_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, BIT_CLKS, 1'b1);
        exp_frame(8'h82, 1'b0, 1'b0);
        send_frame(8'h82, BIT_CLKS, 1'b1);
        wait_drain();
        chk("ovr_data", 32'(bus.data_out), 32'h81);
        chk("ovr_flag", 32'(bus.overrun),  32'd1);
        do_rd();

        // Read collision on the result cycle
        exp_frame(8'h83, 1'b0, 1'b0);
        send_frame(8'h83, BIT_CLKS, 1'b1);
        wait_drain();
        exp_frame(8'h84, 1'b1, 1'b1);
        fork
            send_frame(8'h84, BIT_CLKS, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk);
                bus.rd = 1'b1;
                @(negedge clk);
                bus.rd = 1'b0;
            end
        join
        wait_drain();
        chk("coll_data", 32'(bus.data_out),   32'h84);
        chk("coll_dv",   32'(bus.data_valid), 32'd1);
        chk("coll_ovr",  32'(bus.overrun),    32'd0);
        do_rd();

        // Reset during data bit 4
        bus.rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rxd = i[0];
            repeat (BIT_CLKS) @(negedge clk);
        end
        bus.rxd = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b0;
        bus.rxd = 1'b1;
        m_data = 8'd0; m_dv = 1'b0; m_cmd = 4'd0; m_ovr = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_dv",  32'(bus.data_valid), 32'd0);
        chk("midrst_cmd", 32'(bus.cmd),        32'd0);
        rst = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        exp_frame(8'h88, 1'b0, 1'b0);
        send_frame(8'h88, BIT_CLKS, 1'b1);
        wait_drain();
        do_rd();

        // +/-2% baud error
        exp_frame(8'h89, 1'b0, 1'b0);
        send_frame(8'h89, BIT_CLKS - 2, 1'b1);
        wait_drain();
        do_rd();
        exp_frame(8'h89, 1'b0, 1'b0);
        send_frame(8'h89, BIT_CLKS + 2, 1'b1);
        wait_drain();
        do_rd();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
